// File: rtl/mux_rr_arb_pkg.sv
// rtl/mux_rr_arb_pkg.sv - shared state encoding for the round-robin mux capture stage
package mux_rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mux_rr_arb_rr_pick.sv
// rtl/mux_rr_arb_rr_pick.sv - combinational round-robin pick: first set req above last, wrapping at SEL-1
module mux_rr_arb_rr_pick #(
  parameter int SEL  = 4,
  parameter int NSEL = $clog2(SEL)
) (
  input  logic [SEL-1:0]  req,
  input  logic [NSEL-1:0] last,
  output logic            any,
  output logic [NSEL-1:0] winner
);

  localparam int NW = NSEL + 1;

  logic [NSEL:0] idx_w;
  logic          found;

  // Walk the rotated request vector starting just above last; wrap at SEL so the
  // winner never lands on an unused slot when SEL is not a power of two.
  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx_w  = '0;
    for (int i = 0; i < SEL; i++) begin
      idx_w = {1'b0, last} + NW'(i) + NW'(1);
      if (idx_w >= NW'(SEL)) begin
        idx_w = idx_w - NW'(SEL);
      end
      if (!found && req[idx_w[NSEL-1:0]]) begin
        winner = idx_w[NSEL-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - round-robin arbiter driving a registered mux select and capturing mux_out to a valid/ready stream
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int SEL   = 4,
  localparam int NSEL  = $clog2(SEL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL-1:0]   req,
  output logic [SEL-1:0]   ack,
  output logic [NSEL-1:0]  sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic [NSEL-1:0]  out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state, state_d;
  logic [NSEL-1:0]  last, last_d, sel_d, out_chan_d, winner;
  logic [WIDTH-1:0] out_data_d;
  logic [SEL-1:0]   ack_d;
  logic             out_valid_d, any;

  mux_rr_arb_rr_pick #(
    .SEL  (SEL),
    .NSEL (NSEL)
  ) u_pick (
    .req    (req),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      last      <= NSEL'(SEL - 1);
      ack       <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      last      <= last_d;
      ack       <= ack_d;
      out_data  <= out_data_d;
      out_chan  <= out_chan_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state;
    sel_d       = sel;
    last_d      = last;
    ack_d       = '0;
    out_data_d  = out_data;
    out_chan_d  = out_chan;
    out_valid_d = out_valid;
    case (state)
      IDLE: begin
        if (any) begin
          sel_d   = winner;
          last_d  = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = mux_out;
        out_chan_d  = sel;
        out_valid_d = 1'b1;
        ack_d[sel]  = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        // The handshake cycle doubles as the next arbitration so back-to-back words cost 2 cycles.
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          if (any) begin
            sel_d   = winner;
            last_d  = winner;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - scoreboard bench for mux_rr_arb with SEL=4 and SEL=3 instances
module tb_mux_rr_arb;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [3:0]   req4, ack4;
  logic [1:0]   sel4, chan4;
  logic [W-1:0] mux4, data4;
  logic         valid4, ready4;
  logic [W-1:0] words4 [4];
  assign mux4 = words4[sel4];

  logic [2:0]   req3, ack3;
  logic [1:0]   sel3, chan3;
  logic [W-1:0] mux3, data3;
  logic         valid3, ready3;
  logic [W-1:0] words3 [4];
  assign mux3 = words3[sel3];

  mux_rr_arb #(.WIDTH(W), .SEL(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .ack(ack4), .sel(sel4), .mux_out(mux4),
    .out_data(data4), .out_chan(chan4), .out_valid(valid4), .out_ready(ready4)
  );

  mux_rr_arb #(.WIDTH(W), .SEL(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .ack(ack3), .sel(sel3), .mux_out(mux3),
    .out_data(data3), .out_chan(chan3), .out_valid(valid3), .out_ready(ready3)
  );

  typedef struct {
    int          chan;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    reset = 1'b1;
    req4 = '0; req3 = '0; ready4 = 1'b0; ready3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sel4 !== 2'd0)    begin errors++; $display("FAIL reset_sel got %0d want 0", sel4); end
    checks++; if (ack4 !== 4'b0)    begin errors++; $display("FAIL reset_ack got %b want 0000", ack4); end
    checks++; if (valid4 !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", valid4); end
    checks++; if (data4 !== 8'h00)  begin errors++; $display("FAIL reset_data got %h want 00", data4); end
    checks++; if (chan4 !== 2'd0)   begin errors++; $display("FAIL reset_chan got %0d want 0", chan4); end
    checks++; if (valid3 !== 1'b0 || sel3 !== 2'd0) begin errors++; $display("FAIL reset_dut3 got valid %b sel %0d want 0 0", valid3, sel3); end
    repeat (3) @(negedge clk);
    checks++; if (valid4 !== 1'b0 || ack4 !== 4'b0 || sel4 !== 2'd0) begin
      errors++; $display("FAIL idle_no_req got valid %b ack %b sel %0d want 0 0000 0", valid4, ack4, sel4);
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    words4[2] = 8'hA5;
    ready4 = 1'b0;
    req4 = 4'b0100;
    sb.push_back('{2, 8'hA5});
    @(negedge clk);
    checks++; if (sel4 !== 2'd2 || valid4 !== 1'b0 || ack4 !== 4'b0) begin
      errors++; $display("FAIL single_sel got sel %0d valid %b ack %b want 2 0 0000", sel4, valid4, ack4);
    end
    @(negedge clk);
    checks++;
    if (ack4 === 4'b0 || sb.size() == 0) begin
      errors++; $display("FAIL single_ack got ack %b want 0100", ack4);
    end else begin
      e = sb.pop_front();
      if (ack4 !== (4'b1 << e.chan) || chan4 !== 2'(e.chan) || data4 !== e.data || valid4 !== 1'b1) begin
        errors++; $display("FAIL single_word got ack %b chan %0d data %h valid %b want %b %0d %h 1",
                           ack4, chan4, data4, valid4, 4'b1 << e.chan, e.chan, e.data);
      end
    end
    req4 = 4'b0;
    @(negedge clk);
    checks++; if (ack4 !== 4'b0 || valid4 !== 1'b1) begin
      errors++; $display("FAIL single_pulse got ack %b valid %b want 0000 1", ack4, valid4);
    end
    ready4 = 1'b1;
    @(negedge clk);
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL single_accept got valid %b want 0", valid4); end
    ready4 = 1'b0;
  endtask

  task automatic test_skip_wrap();
    exp_t e;
    logic stray = 1'b0;
    words4[0] = 8'h11; words4[1] = 8'h22;
    sb.push_back('{0, 8'h11});
    sb.push_back('{1, 8'h22});
    req4 = 4'b0011;
    ready4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((ack4 & 4'b1100) != 4'b0) stray = 1'b1;
      if (ack4 !== 4'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL skip_extra got ack %b want none", ack4);
        end else begin
          e = sb.pop_front();
          if (ack4 !== (4'b1 << e.chan) || chan4 !== 2'(e.chan) || data4 !== e.data) begin
            errors++; $display("FAIL skip_word got ack %b chan %0d data %h want %b %0d %h",
                               ack4, chan4, data4, 4'b1 << e.chan, e.chan, e.data);
          end
        end
        req4 = req4 & ~ack4;
      end
      if (sb.size() == 0 && req4 == 4'b0) break;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL skip_timeout got %0d pending want 0", sb.size()); end
    checks++; if (stray) begin errors++; $display("FAIL skip_stray got ack on ch2/3 want none"); end
    ready4 = 1'b0;
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   n = 0;
    int   last_cyc = -1;
    do_reset();
    words4[0] = 8'h10; words4[1] = 8'h21; words4[2] = 8'h32; words4[3] = 8'h43;
    foreach (words4[k]) if (k < 2) sb.push_back('{k, words4[k]});
    for (int k = 0; k < 4; k++) sb.push_front('{3 - k, words4[3 - k]});
    req4 = 4'b1111;
    ready4 = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (ack4 !== 4'b0) begin
        e = sb.pop_front();
        checks++;
        if (ack4 !== (4'b1 << e.chan) || chan4 !== 2'(e.chan) || data4 !== e.data || valid4 !== 1'b1) begin
          errors++; $display("FAIL rr_word%0d got ack %b chan %0d data %h want %b %0d %h",
                             n, ack4, chan4, data4, 4'b1 << e.chan, e.chan, e.data);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin errors++; $display("FAIL rr_rate got %0d cycles want 2", cyc - last_cyc); end
        end
        last_cyc = cyc;
        n++;
        if (sb.size() == 0) req4 = 4'b0;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL rr_count got %0d want 6", n); end
    @(negedge clk);
    ready4 = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic got = 1'b0;
    do_reset();
    words4[0] = 8'hC3; words4[1] = 8'h3C;
    sb.push_back('{0, 8'hC3});
    sb.push_back('{1, 8'h3C});
    req4 = 4'b0011;
    ready4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack4 !== 4'b0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL bp_first got no ack want 0001");
    end else begin
      e = sb.pop_front();
      if (ack4 !== (4'b1 << e.chan) || chan4 !== 2'(e.chan) || data4 !== e.data) begin
        errors++; $display("FAIL bp_first got ack %b chan %0d data %h want %b %0d %h",
                           ack4, chan4, data4, 4'b1 << e.chan, e.chan, e.data);
      end
    end
    req4 = req4 & ~ack4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({valid4, data4, chan4, ack4, sel4} !== {1'b1, 8'hC3, 2'd0, 4'b0, 2'd0}) begin
        errors++; $display("FAIL bp_hold%0d got valid %b data %h chan %0d ack %b sel %0d want 1 c3 0 0000 0",
                           i, valid4, data4, chan4, ack4, sel4);
      end
    end
    ready4 = 1'b1;
    @(negedge clk);
    checks++; if (sel4 !== 2'd1 || valid4 !== 1'b0) begin
      errors++; $display("FAIL bp_regrant got sel %0d valid %b want 1 0", sel4, valid4);
    end
    @(negedge clk);
    checks++;
    if (ack4 === 4'b0 || sb.size() == 0) begin
      errors++; $display("FAIL bp_second got ack %b want 0010", ack4);
    end else begin
      e = sb.pop_front();
      if (ack4 !== (4'b1 << e.chan) || chan4 !== 2'(e.chan) || data4 !== e.data) begin
        errors++; $display("FAIL bp_second got ack %b chan %0d data %h want %b %0d %h",
                           ack4, chan4, data4, 4'b1 << e.chan, e.chan, e.data);
      end
    end
    req4 = 4'b0;
    @(negedge clk);
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL bp_drain got valid %b want 0", valid4); end
    ready4 = 1'b0;
  endtask

  task automatic test_non_pow2();
    exp_t e;
    logic bad_sel = 1'b0;
    int   n = 0;
    do_reset();
    words3[0] = 8'hA0; words3[1] = 8'hB1; words3[2] = 8'hC2; words3[3] = 8'hEE;
    sb.push_back('{0, 8'hA0});
    sb.push_back('{1, 8'hB1});
    sb.push_back('{2, 8'hC2});
    sb.push_back('{0, 8'hA0});
    req3 = 3'b111;
    ready3 = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(negedge clk);
      if (sel3 >= 2'd3) bad_sel = 1'b1;
      if (ack3 !== 3'b0) begin
        e = sb.pop_front();
        checks++;
        if (ack3 !== (3'b1 << e.chan) || chan3 !== 2'(e.chan) || data3 !== e.data) begin
          errors++; $display("FAIL np2_word%0d got ack %b chan %0d data %h want %b %0d %h",
                             n, ack3, chan3, data3, 3'b1 << e.chan, e.chan, e.data);
        end
        n++;
        if (sb.size() == 0) req3 = 3'b0;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL np2_count got %0d want 4", n); end
    checks++; if (bad_sel) begin errors++; $display("FAIL np2_sel got sel 3 want < 3"); end
    @(negedge clk);
    ready3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic got = 1'b0;
    do_reset();
    words4[2] = 8'hA5;
    req4 = 4'b0100;
    ready4 = 1'b0;
    for (int i = 0; i < 10 && !valid4; i++) @(negedge clk);
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL mid_setup got valid %b want 1", valid4); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (valid4 !== 1'b0 || sel4 !== 2'd0 || ack4 !== 4'b0) begin
      errors++; $display("FAIL mid_reset got valid %b sel %0d ack %b want 0 0 0000", valid4, sel4, ack4);
    end
    reset = 1'b0;
    words4[0] = 8'h5A; words4[3] = 8'h77;
    req4 = 4'b1001;
    sb.push_back('{0, 8'h5A});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack4 !== 4'b0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL mid_grant got no ack want 0001");
    end else begin
      e = sb.pop_front();
      if (ack4 !== (4'b1 << e.chan) || chan4 !== 2'(e.chan) || data4 !== e.data) begin
        errors++; $display("FAIL mid_grant got ack %b chan %0d data %h want %b %0d %h",
                           ack4, chan4, data4, 4'b1 << e.chan, e.chan, e.data);
      end
    end
    req4 = 4'b0;
    sb.delete();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin words4[k] = '0; words3[k] = '0; end
    test_reset();
    test_single();
    test_skip_wrap();
    test_round_robin();
    test_backpressure();
    test_non_pow2();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Round-robin arbiter and capture stage that sits directly upstream of the generic MUX.
- Scans SEL producer channels, each holding a WIDTH-bit word.
- Drives the MUX select with a registered value and captures the MUX output.
- Presents the captured word, tagged with its channel number, to a single downstream consumer over a valid/ready handshake.
- Typical use: funnelling per-channel results into one readout stream.

Parameters:
- WIDTH, "required", bit width of each channel word; must be >= 1.
- SEL, "required", number of channels; must be >= 2.
- NSEL (localparam), clog2(SEL), width of the select/channel index.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- req  in  SEL  per-channel "word available"; bit i high while channel i holds a word.
- ack  out  SEL  one-cycle pulse on bit i when channel i's word is captured.
- sel  out  NSEL  registered select driven to the MUX sel input.
- mux_out  in  WIDTH  MUX out, combinational function of sel.
- out_data  out  WIDTH  captured word.
- out_chan  out  NSEL  channel index of out_data.
- out_valid  out  1  out_data/out_chan valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: sel=0, ack=0, out_data=0, out_chan=0, out_valid=0, last-grant pointer = SEL-1, so channel 0 has first priority. State = IDLE.
- States:
  - IDLE:
    - If |req, pick the winner: the first set req bit searching upward from last+1, wrapping at SEL-1 -> 0.
    - Register sel <= winner and last <= winner, then go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD:
    - Lasts exactly one cycle; mux_out now reflects the registered sel.
    - Set out_data <= mux_out, out_chan <= sel, out_valid <= 1.
    - Pulse ack[sel] for this single cycle.
    - Go to HOLD.
  - HOLD:
    - Hold out_data, out_chan and out_valid stable until out_valid && out_ready.
    - On that handshake cycle, out_valid <= 0, and arbitrate in the same cycle exactly as IDLE does.
    - If |req, go to LOAD with the new sel; else go to IDLE.
- Latency and throughput:
  - req rising in IDLE at cycle N gives sel at N+1, out_valid and ack at N+2.
  - Maximum throughput is one word per 2 cycles with out_ready tied high.
- Arbitration timing:
  - req is sampled only at arbitration. Deassertion after the grant does not cancel the capture.
  - A channel must hold its word and req until it sees ack.
  - ack never asserts for a channel whose req was low at grant.
- Fairness: strict rotation. With all req high, grants go 0,1,...,SEL-1,0,...; no channel is granted twice while another requesting channel waits.
- Non-power-of-2 SEL: the winner is always < SEL, so sel never addresses an unused MUX slot. Arbitration wraps at SEL-1, not at 2^NSEL-1.
- out_ready high while out_valid is low has no effect.
- Reset mid-operation: a captured-but-unaccepted word is discarded, and no further ack is issued for it.
- ack is a registered output and is never combinational from req.

Decomposition:
- clog2 comes from the shared kiwi.vh include; no new package is required.
- Optional shared constant: the state encoding, as localparams local to the module (IDLE=0, LOAD=1, HOLD=2).
- One sub-module is natural: rr_pick.
  - Purely combinational: inputs req[SEL], last[NSEL]; outputs any, winner[NSEL].
  - Implemented as a rotate / priority-encode / unrotate.
  - Reusable by other arbiters in the design.
- The MUX itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset and single request: SEL=4, WIDTH=8. After reset, req=4'b0100 with channel 2 word 8'hA5. Expect sel=2 at cycle+1; out_valid=1, out_data=A5, out_chan=2, ack=4'b0100 for one cycle at cycle+2.
- Round-robin: req=4'b1111 held, out_ready=1, each channel re-asserts after ack. Expect out_chan sequence 0,1,2,3,0,1, one word every 2 cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid. Expect out_data and out_chan stable, no second ack, no new sel change. out_ready=1 then gives the handshake and the next grant in the same cycle.
- Non-power-of-2: SEL=3, req=3'b111, out_ready=1. Expect grants 0,1,2,0; sel never equals 3.
- Skip and wrap: last grant = 2, req=4'b0011. Expect the next grant 0, then 1; channels 2 and 3 are never acked.
- Reset mid-operation: assert reset while in HOLD with out_valid=1. Expect next-cycle out_valid=0, sel=0, ack=0. After reset, the first grant with req=4'b1001 goes to channel 0.
